// File: rtl/block_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : block_mem_responder
// Brief    : Main-memory responder for cache refill/write-back. It serves
//            128-bit block reads and writes after a fixed latency and uses a
//            busywait handshake. Define MEM_STATS_EN to add the
//            read_count/write_count ports.
// Revision : 1.0 - initial release
// ============================================================================
module block_mem_responder #(
   parameter int ADDR_WIDTH = 6,
   parameter int LATENCY    = 4
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  read,
   input  logic                  write,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [127:0]          writedata,
   output logic [127:0]          readdata,
   output logic                  busywait
`ifdef MEM_STATS_EN
   ,
   output logic [31:0]           read_count,
   output logic [31:0]           write_count
`endif
);

   localparam int         DEPTH    = 1 << ADDR_WIDTH;
   localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e                  state_q;
   logic [7:0]              cnt_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [127:0]            wdata_q;
   logic                    op_wr_q;
   logic [127:0]            rdata_q;
   logic [127:0]            mem_q [DEPTH];
   logic                    access_d;
`ifdef MEM_STATS_EN
   logic [31:0]             rd_cnt_q;
   logic [31:0]             wr_cnt_q;
`endif

   // The access happens on the edge that leaves BUSY.
   assign access_d = (state_q == S_BUSY) && (cnt_q == 8'd0);

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= S_IDLE;
         cnt_q    <= 8'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
         op_wr_q  <= 1'b0;
         rdata_q  <= '0;
`ifdef MEM_STATS_EN
         rd_cnt_q <= 32'd0;
         wr_cnt_q <= 32'd0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (read || write) begin
                  addr_q  <= address;
                  wdata_q <= writedata;
                  op_wr_q <= write;
                  cnt_q   <= CNT_LOAD;
                  state_q <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (cnt_q == 8'd0) begin
                  if (!op_wr_q) begin
                     rdata_q <= mem_q[addr_q];
                  end
`ifdef MEM_STATS_EN
                  if (op_wr_q) begin
                     wr_cnt_q <= wr_cnt_q + 32'd1;
                  end else begin
                     rd_cnt_q <= rd_cnt_q + 32'd1;
                  end
`endif
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - 8'd1;
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // The array has no reset, so it can map onto block RAM.
   // RESET gating stops a write if the reset lands on the completing edge.
   always_ff @(posedge CLK) begin
      if (RESET && access_d && op_wr_q) begin
         mem_q[addr_q] <= wdata_q;
      end
   end

   always_comb begin
      busywait = 1'b0;
      if (RESET) begin
         case (state_q)
            S_IDLE:  busywait = read | write;
            S_BUSY:  busywait = 1'b1;
            default: busywait = 1'b0;
         endcase
      end
   end

   assign readdata = rdata_q;
`ifdef MEM_STATS_EN
   assign read_count  = rd_cnt_q;
   assign write_count = wr_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_block_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_block_mem_responder
// Brief    : Randomized self-checking bench for block_mem_responder. It checks
//            the DUT against an array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_mem_responder;

   localparam int C_AW    = 6;
   localparam int C_LAT   = 4;
   localparam int C_DEPTH = 1 << C_AW;

   logic            clk         = 1'b0;
   logic            rst_n       = 1'b0;
   logic            r_read      = 1'b0;
   logic            r_write     = 1'b0;
   logic [C_AW-1:0] r_address   = '0;
   logic [127:0]    r_writedata = '0;
   logic [127:0]    w_readdata;
   logic            w_busywait;
`ifdef MEM_STATS_EN
   logic [31:0]     w_read_count;
   logic [31:0]     w_write_count;
`endif

   int n_vec = 0;
   int n_err = 0;

   logic [127:0] m_mem [C_DEPTH];
   logic [127:0] m_rdata;
   int unsigned  m_rd_cnt;
   int unsigned  m_wr_cnt;
   logic [127:0] m_old;

   always #5 clk = ~clk;

   block_mem_responder #(
      .ADDR_WIDTH (C_AW),
      .LATENCY    (C_LAT)
   ) u_dut (
      .CLK         (clk),
      .RESET       (rst_n),
      .read        (r_read),
      .write       (r_write),
      .address     (r_address),
      .writedata   (r_writedata),
      .readdata    (w_readdata),
      .busywait    (w_busywait)
`ifdef MEM_STATS_EN
      ,
      .read_count  (w_read_count),
      .write_count (w_write_count)
`endif
   );

   task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One transaction. The caller starts it just after a rising edge while the
   // DUT is in IDLE. A write wins when both requests are set.
   task automatic txn(input bit wr, input bit rd, input logic [C_AW-1:0] a,
                      input logic [127:0] d, input bit keep, input bit scramble);
      int cyc;
      r_write     = wr;
      r_read      = rd;
      r_address   = a;
      r_writedata = d;
      cyc = 0;
      forever begin
         @(negedge clk);
         if (!w_busywait) break;
         if (cyc > 20) begin
            chk_eq("busywait_timeout", 128'(cyc), 128'(C_LAT + 1));
            break;
         end
         cyc++;
         if (scramble && cyc >= 2) begin
            r_address   = C_AW'($urandom);
            r_writedata = rnd128();
            if ($urandom_range(0, 3) == 0) begin
               r_read  = 1'b0;
               r_write = 1'b0;
            end
         end
      end
      chk_eq("latency", 128'(cyc), 128'(C_LAT + 1));
      if (wr) begin
         m_mem[a] = d;
         m_wr_cnt++;
      end else begin
         m_rdata = m_mem[a];
         m_rd_cnt++;
      end
      chk_eq(wr ? "readdata_after_write" : "readdata_after_read", w_readdata, m_rdata);
      @(posedge clk);
      #1;
      if (!keep) begin
         r_read  = 1'b0;
         r_write = 1'b0;
         @(negedge clk);
         chk_eq("idle_busywait", 128'(w_busywait), 128'(0));
         @(posedge clk);
         #1;
      end
   endtask

`ifdef MEM_STATS_EN
   task automatic chk_stats();
      chk_eq("read_count", 128'(w_read_count), 128'(m_rd_cnt));
      chk_eq("write_count", 128'(w_write_count), 128'(m_wr_cnt));
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      m_rdata  = '0;
      m_rd_cnt = 0;
      m_wr_cnt = 0;

      // A read is held while reset is low.
      r_read = 1'b1;
      repeat (2) begin
         @(negedge clk);
         chk_eq("reset_busywait", 128'(w_busywait), 128'(0));
         chk_eq("reset_readdata", w_readdata, 128'h0);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      chk_eq("release_busywait", 128'(w_busywait), 128'(1));
      r_read = 1'b0;
      @(posedge clk);
      #1;
`ifdef MEM_STATS_EN
      chk_stats();
`endif

      // Fill every block so the model knows all contents.
      for (int i = 0; i < C_DEPTH; i++) begin
         txn(1'b1, 1'b0, C_AW'(i), rnd128(), 1'($urandom_range(0, 1)), 1'b0);
      end

      txn(1'b1, 1'b0, 6'h05, 128'h0000_0004_0000_0003_0000_0002_0000_0001, 1'b0, 1'b0);
      txn(1'b0, 1'b1, 6'h05, 128'h0, 1'b0, 1'b0);
      chk_eq("block5_readback", w_readdata, 128'h0000_0004_0000_0003_0000_0002_0000_0001);

      // Both requests high: the write must win.
      m_old = m_rdata;
      txn(1'b1, 1'b1, 6'h0A, 128'hA5, 1'b0, 1'b0);
      chk_eq("both_high_readdata_held", w_readdata, m_old);
      txn(1'b0, 1'b1, 6'h0A, 128'h0, 1'b0, 1'b0);
      chk_eq("both_high_readback", w_readdata, 128'hA5);

      // Inputs that change during BUSY are ignored. Then run back-to-back reads.
      txn(1'b0, 1'b1, 6'h01, 128'h0, 1'b1, 1'b1);
      txn(1'b0, 1'b1, 6'h02, 128'h0, 1'b1, 1'b0);
      txn(1'b0, 1'b1, 6'h03, 128'h0, 1'b0, 1'b0);

      for (int i = 0; i < 150; i++) begin
         txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) | 1'b1,
             C_AW'($urandom), rnd128(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      // Reset during the second BUSY cycle of a write to 0x07.
      r_write     = 1'b1;
      r_address   = 6'h07;
      r_writedata = rnd128();
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_eq("midreset_busywait", 128'(w_busywait), 128'(0));
      chk_eq("midreset_readdata", w_readdata, 128'h0);
      r_write  = 1'b0;
      m_rdata  = '0;
      m_rd_cnt = 0;
      m_wr_cnt = 0;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(negedge clk);
      chk_eq("post_reset_idle", 128'(w_busywait), 128'(0));
      @(posedge clk);
      #1;
      txn(1'b0, 1'b1, 6'h07, 128'h0, 1'b0, 1'b0);

      // Reads and writes for the statistics counters.
      txn(1'b0, 1'b1, 6'h05, 128'h0, 1'b0, 1'b0);
      txn(1'b1, 1'b0, 6'h10, rnd128(), 1'b1, 1'b0);
      txn(1'b0, 1'b1, 6'h10, 128'h0, 1'b0, 1'b0);
      txn(1'b1, 1'b0, 6'h11, rnd128(), 1'b0, 1'b0);
`ifdef MEM_STATS_EN
      chk_stats();
      rst_n = 1'b0;
      #1;
      m_rd_cnt = 0;
      m_wr_cnt = 0;
      chk_stats();
      @(posedge clk);
      #3;
      rst_n = 1'b1;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
